// File: rtl/calibration_sequencer.sv
// rtl/calibration_sequencer.sv - steps the LED-ID display through every address bit
// and handshakes one camera capture per bit.
module calibration_sequencer #(
   parameter int NUM_LEDS       = 50,
   parameter int SETTLE_CYCLES  = 2_000_000,
   parameter int TIMEOUT_CYCLES = 8_000_000,
   localparam int NUM_BITS      = $clog2(NUM_LEDS),
   localparam int BIT_IDX_W     = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 frame_valid,
   input  logic                 capture_ack,
   output logic                 shower_rst,
   output logic                 increment_bit,
   output logic                 capture_req,
   output logic [BIT_IDX_W-1:0] capture_bit,
   output logic                 busy,
   output logic                 done,
   output logic                 error
);

   localparam int MAX_CNT = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CNT + 1);

   localparam logic [BIT_IDX_W-1:0] LAST_BIT     = BIT_IDX_W'(NUM_BITS - 1);
   localparam logic [CNT_W-1:0]     SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]     TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]     BLANK_LAST   = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE, BLANK, WAIT_VALID, SETTLE, CAPTURE, STEP, DONE, ERROR
   } state_t;

   state_t               state;
   logic [BIT_IDX_W-1:0] bit_idx;
   logic [CNT_W-1:0]     counter;

   always_ff @(posedge clk) begin
      if (rst || abort) begin
         state         <= IDLE;
         bit_idx       <= '0;
         counter       <= '0;
         shower_rst    <= 1'b0;
         increment_bit <= 1'b0;
         capture_req   <= 1'b0;
         capture_bit   <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         error         <= 1'b0;
      end else begin
         // pulses last exactly one cycle unless re-armed below
         shower_rst    <= 1'b0;
         increment_bit <= 1'b0;
         case (state)
            IDLE, DONE, ERROR: begin
               if (start) begin
                  state      <= BLANK;
                  shower_rst <= 1'b1;
                  bit_idx    <= '0;
                  counter    <= '0;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  error      <= 1'b0;
               end
            end
            BLANK: begin
               // display output lags a pulse by one edge, so frame_valid is untrustworthy here
               if (counter == BLANK_LAST) begin
                  state   <= WAIT_VALID;
                  counter <= '0;
               end else begin
                  counter <= counter + 1'b1;
               end
            end
            WAIT_VALID: begin
               if (frame_valid) begin
                  state   <= SETTLE;
                  counter <= '0;
               end else if (counter == TIMEOUT_LAST) begin
                  state <= ERROR;
                  error <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  counter <= counter + 1'b1;
               end
            end
            SETTLE: begin
               if (!frame_valid) begin
                  state   <= WAIT_VALID;
                  counter <= '0;
               end else if (counter == SETTLE_LAST) begin
                  state       <= CAPTURE;
                  capture_req <= 1'b1;
                  capture_bit <= bit_idx;
               end else begin
                  counter <= counter + 1'b1;
               end
            end
            CAPTURE: begin
               if (capture_req && capture_ack) begin
                  capture_req <= 1'b0;
                  state       <= STEP;
               end
            end
            STEP: begin
               if (bit_idx == LAST_BIT) begin
                  state <= DONE;
                  done  <= 1'b1;
                  busy  <= 1'b0;
               end else begin
                  state         <= BLANK;
                  increment_bit <= 1'b1;
                  bit_idx       <= bit_idx + 1'b1;
                  counter       <= '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_calibration_sequencer.sv
// tb/tb_calibration_sequencer.sv - cycle-table and scenario checks for calibration_sequencer
// (NUM_LEDS=8 -> 3 bits, SETTLE=4, TIMEOUT=16).
module tb_calibration_sequencer;

   logic       clk = 1'b0;
   logic       rst, start, abort, frame_valid, capture_ack;
   logic       shower_rst, increment_bit, capture_req, busy, done, error;
   logic [1:0] capture_bit;

   int n_checks = 0;
   int n_errors = 0;

   calibration_sequencer #(
      .NUM_LEDS(8), .SETTLE_CYCLES(4), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .frame_valid(frame_valid), .capture_ack(capture_ack),
      .shower_rst(shower_rst), .increment_bit(increment_bit),
      .capture_req(capture_req), .capture_bit(capture_bit),
      .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst, start, abort, fv, ack;
      logic [7:0] exp;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [7:0] outs();
      return {shower_rst, increment_bit, capture_req, capture_bit, busy, done, error};
   endfunction

   task automatic add(input logic r, s, a, f, k,
                      input logic sh, inc, req, input logic [1:0] b,
                      input logic bz, dn, er);
      vec_t v;
      v.rst = r; v.start = s; v.abort = a; v.fv = f; v.ack = k;
      v.exp = {sh, inc, req, b, bz, dn, er};
      tbl.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic reset_dut();
      rst = 1'b1; start = 1'b0; abort = 1'b0; frame_valid = 1'b0; capture_ack = 1'b0;
      step();
      rst = 1'b0;
   endtask

   task automatic wait_req(input string name);
      int n;
      n = 0;
      while (!capture_req && n < 100) begin
         step();
         n++;
      end
      if (!capture_req) chk({name, "_req_timeout"}, 0, 1);
   endtask

   initial begin
      int shw, incs, caps, fv_cd, ack_cd;
      logic req_seen, seen;
      logic [1:0] bits[$];

      // constant frame_valid, ack one cycle after req, then start held into DONE and abort vs start
      add(1,0,0,1,0, 0,0,0,2'd0,0,0,0);
      add(0,0,0,1,0, 0,0,0,2'd0,0,0,0);
      add(0,1,0,1,0, 1,0,0,2'd0,1,0,0);
      for (int i = 0; i < 6; i++) add(0,0,0,1,0, 0,0,0,2'd0,1,0,0);
      add(0,0,0,1,0, 0,0,1,2'd0,1,0,0);
      add(0,0,0,1,0, 0,0,1,2'd0,1,0,0);
      add(0,0,0,1,1, 0,0,0,2'd0,1,0,0);
      add(0,0,0,1,0, 0,1,0,2'd0,1,0,0);
      for (int i = 0; i < 6; i++) add(0,0,0,1,0, 0,0,0,2'd0,1,0,0);
      add(0,0,0,1,0, 0,0,1,2'd1,1,0,0);
      add(0,0,0,1,1, 0,0,0,2'd1,1,0,0);
      add(0,0,0,1,0, 0,1,0,2'd1,1,0,0);
      for (int i = 0; i < 6; i++) add(0,0,0,1,0, 0,0,0,2'd1,1,0,0);
      add(0,0,0,1,0, 0,0,1,2'd2,1,0,0);
      add(0,0,0,1,1, 0,0,0,2'd2,1,0,0);
      add(0,0,0,1,0, 0,0,0,2'd2,0,1,0);
      add(0,1,0,1,0, 1,0,0,2'd2,1,0,0);
      add(0,0,0,1,0, 0,0,0,2'd2,1,0,0);
      add(0,1,1,1,0, 0,0,0,2'd0,0,0,0);
      add(0,1,0,1,0, 1,0,0,2'd0,1,0,0);
      add(0,0,1,1,0, 0,0,0,2'd0,0,0,0);

      foreach (tbl[i]) begin
         rst = tbl[i].rst; start = tbl[i].start; abort = tbl[i].abort;
         frame_valid = tbl[i].fv; capture_ack = tbl[i].ack;
         step();
         chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
      end

      // full sweep: frame_valid 3 cycles after each pulse, ack 2 cycles after req
      reset_dut();
      start = 1'b1;
      step();
      start = 1'b0;
      shw = 0; incs = 0; caps = 0; fv_cd = -1; ack_cd = -1; req_seen = 1'b0;
      for (int c = 0; c < 400 && !done; c++) begin
         capture_ack = 1'b0;
         if (shower_rst) shw++;
         if (increment_bit) incs++;
         if (shower_rst || increment_bit) begin
            frame_valid = 1'b0;
            fv_cd = 3;
         end
         if (capture_req && !req_seen) begin
            bits.push_back(capture_bit);
            caps++;
            ack_cd = 2;
         end
         req_seen = capture_req;
         if (fv_cd > 0) fv_cd--;
         if (fv_cd == 0) begin frame_valid = 1'b1; fv_cd = -1; end
         if (ack_cd > 0) ack_cd--;
         if (ack_cd == 0) begin capture_ack = 1'b1; ack_cd = -1; end
         step();
      end
      capture_ack = 1'b0;
      chk("sweep_done", done, 1);
      chk("sweep_busy", busy, 0);
      chk("sweep_shower", shw, 1);
      chk("sweep_incs", incs, 2);
      chk("sweep_caps", caps, 3);
      for (int i = 0; i < 3; i++)
         chk($sformatf("sweep_bit%0d", i), (i < bits.size()) ? bits[i] : 2'd3, i);

      // frame_valid stuck low: error exactly 16 cycles after WAIT_VALID entry
      reset_dut();
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         step();
         seen = seen | error | capture_req;
      end
      chk("timeout_early", seen, 0);
      step();
      chk("timeout_error", error, 1);
      chk("timeout_busy", busy, 0);
      start = 1'b1;
      step();
      start = 1'b0;
      chk("restart_clears_error", {error, shower_rst}, 2'b01);

      // frame_valid drops mid-settle: settle count restarts from its return
      reset_dut();
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      frame_valid = 1'b1;
      step();
      step();
      step();
      frame_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         seen = seen | capture_req;
      end
      frame_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         seen = seen | capture_req;
      end
      chk("settle_restart_early", seen, 0);
      step();
      chk("settle_restart_req", capture_req, 1);

      // abort together with ack on bit 1
      reset_dut();
      frame_valid = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      wait_req("abort_bit0");
      capture_ack = 1'b1;
      step();
      capture_ack = 1'b0;
      wait_req("abort_bit1");
      chk("abort_bit1_idx", capture_bit, 1);
      capture_ack = 1'b1;
      abort = 1'b1;
      step();
      capture_ack = 1'b0;
      abort = 1'b0;
      chk("abort_outs", outs(), 8'h00);
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         seen = seen | increment_bit | busy | done;
      end
      chk("abort_quiet", seen, 0);
      start = 1'b1;
      step();
      start = 1'b0;
      wait_req("abort_restart");
      chk("abort_restart_bit", capture_bit, 0);

      // reset during CAPTURE; later ack must be ignored
      reset_dut();
      frame_valid = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      wait_req("rst_cap");
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("rst_outs", outs(), 8'h00);
      capture_ack = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         seen = seen | (outs() != 8'h00);
      end
      capture_ack = 1'b0;
      chk("rst_ack_ignored", seen, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
